// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//
// Counter-based scoreboard and hazard unit for the 5-stage RV32 pipeline,
// placed at the ID/EX boundary. It generates the ID stall.
//
// Each architectural register r >= 1 has a down-counter cnt[r]. The counter
// holds the number of cycles left until the register's pending result can be
// forwarded to an EX consumer. A consumer may issue once its source counter
// is <= 1. x0 is never tracked.
//
// A separate down-counter, mdu_cnt, tracks the shared non-pipelined
// iterative unit (MDU).
//
// The youngest issued instruction can be cancelled by an EX-stage flush
// (ex_kill). When that happens, its destination counter is rolled back to
// the value the previous writer would have reached.
//
// Optional feature, off by default:
//   SB_WAW_CHECK_EN  When defined, ID also stalls when a write to rd would
//                    complete before an older, longer write to the same rd.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   id_valid            ID holds a valid instruction
//   id_rs1/id_rs2       source register addresses
//   id_rs1/2_used       the source is actually read
//   id_rd, id_rd_we     destination register and write enable
//   id_lat              result latency (0 is treated as 1, saturates at MAX_LAT)
//   id_long             instruction uses the iterative unit
//   ex_kill             EX-stage flush; cancels the instruction in EX
//   stall               combinational ID stall
//   busy_mask           registered; bit r set while cnt[r] != 0
//   mdu_busy            registered; set while mdu_cnt != 0
module pipe_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int MAX_LAT  = 8,
    parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_rd_we,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                id_long,
    input  logic                ex_kill,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                mdu_busy
);

    localparam logic [LAT_W-1:0] LAT_ZERO = '0;
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_TWO  = LAT_W'(2);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0]    cnt     [NUM_REGS];
    logic [LAT_W-1:0]    cnt_nxt [NUM_REGS];
    logic [LAT_W-1:0]    mdu_cnt;
    logic [LAT_W-1:0]    mdu_nxt;
    logic [NUM_REGS-1:0] busy_nxt;

    logic                last_vld;
    logic                last_we;
    logic                last_long;
    logic [REG_AW-1:0]   last_rd;
    logic [LAT_W-1:0]    last_prev_cnt;

    logic [LAT_W-1:0]    lat_n;
    logic [LAT_W-1:0]    restore_cnt;
    logic                raw1;
    logic                raw2;
    logic                struct_haz;
    logic                waw_haz;
    logic                issue;

    assign lat_n = (id_lat == LAT_ZERO) ? LAT_ONE :
                   (id_lat > LAT_MAX)   ? LAT_MAX : id_lat;

    // The cancelled instruction overwrote the previous writer's count one
    // cycle ago. That writer would have decremented on both edges since then.
    assign restore_cnt = (last_prev_cnt > LAT_TWO) ? (last_prev_cnt - LAT_TWO) : LAT_ZERO;

    // A count of 1 means the result is forwardable on the next edge, so a
    // consumer may issue now.
    assign raw1       = id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] > LAT_ONE);
    assign raw2       = id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] > LAT_ONE);
    assign struct_haz = id_long && (mdu_cnt > LAT_ONE);

`ifdef SB_WAW_CHECK_EN
    assign waw_haz = id_rd_we && (id_rd != '0) && (cnt[id_rd] > lat_n);
`else
    assign waw_haz = 1'b0;
`endif

    // ID is being flushed on ex_kill, so no stall is raised in that cycle.
    assign stall = id_valid && !ex_kill && (raw1 || raw2 || struct_haz || waw_haz);
    assign issue = id_valid && !stall && !ex_kill;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] != LAT_ZERO) ? (cnt[r] - LAT_ONE) : LAT_ZERO;
        end
        mdu_nxt = (mdu_cnt != LAT_ZERO) ? (mdu_cnt - LAT_ONE) : LAT_ZERO;

        if (ex_kill) begin
            if (last_vld) begin
                if (last_we && (last_rd != '0)) begin
                    cnt_nxt[last_rd] = restore_cnt;
                end
                if (last_long) begin
                    mdu_nxt = LAT_ZERO;
                end
            end
        end else if (issue) begin
            if (id_rd_we && (id_rd != '0)) begin
                cnt_nxt[id_rd] = lat_n;
            end
            if (id_long) begin
                mdu_nxt = lat_n;
            end
        end

        cnt_nxt[0] = LAT_ZERO;

        busy_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_nxt[r] = (cnt_nxt[r] != LAT_ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= LAT_ZERO;
            end
            mdu_cnt       <= LAT_ZERO;
            busy_mask     <= '0;
            mdu_busy      <= 1'b0;
            last_vld      <= 1'b0;
            last_we       <= 1'b0;
            last_long     <= 1'b0;
            last_rd       <= '0;
            last_prev_cnt <= LAT_ZERO;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            mdu_cnt   <= mdu_nxt;
            busy_mask <= busy_nxt;
            mdu_busy  <= (mdu_nxt != LAT_ZERO);
            last_vld  <= issue;
            if (issue) begin
                last_rd       <= id_rd;
                last_we       <= id_rd_we;
                last_long     <= id_long;
                last_prev_cnt <= cnt[id_rd];
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic [3:0]  id_lat;
    logic        id_long;
    logic        ex_kill;
    logic        stall;
    logic [31:0] busy_mask;
    logic        mdu_busy;

    always #5 clk = ~clk;

    pipe_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_lat      (id_lat),
        .id_long     (id_long),
        .ex_kill     (ex_kill),
        .stall       (stall),
        .busy_mask   (busy_mask),
        .mdu_busy    (mdu_busy)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: absolute cycle at which each pending result becomes
    // forwardable. A consumer in cycle c must wait while c < ready; the
    // register shows busy while c <= ready.
    int cyc = 0;
    int ready [32];
    int mdu_ready;
    bit last_vld;
    int last_rd;
    bit last_we;
    bit last_long;
    int last_prev;

    function automatic int norm_lat(int l);
        if (l == 0) return 1;
        if (l > 8) return 8;
        return l;
    endfunction

    function automatic bit model_stall();
        bit s = 1'b0;
`ifdef SB_WAW_CHECK_EN
        int l = norm_lat(int'(id_lat));
`endif
        if (ex_kill || !id_valid) return 1'b0;
        if (id_rs1_used && id_rs1 != 5'd0 && cyc < ready[id_rs1]) s = 1'b1;
        if (id_rs2_used && id_rs2 != 5'd0 && cyc < ready[id_rs2]) s = 1'b1;
        if (id_long && cyc < mdu_ready) s = 1'b1;
`ifdef SB_WAW_CHECK_EN
        if (id_rd_we && id_rd != 5'd0 && (ready[id_rd] + 1 - cyc) > l) s = 1'b1;
`endif
        return s;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (cyc <= ready[r]);
        return b;
    endfunction

    function automatic bit model_mdu_busy();
        return cyc <= mdu_ready;
    endfunction

    // Advance the model by the current inputs, then advance the clock.
    task automatic tick();
        bit s;
        bit iss;
        if (reset) begin
            for (int r = 0; r < 32; r++) ready[r] = -1000;
            mdu_ready = -1000;
            last_vld  = 1'b0;
        end else begin
            s   = model_stall();
            iss = id_valid && !s && !ex_kill;
            if (ex_kill) begin
                if (last_vld) begin
                    if (last_we && last_rd != 0) ready[last_rd] = last_prev;
                    if (last_long) mdu_ready = cyc;
                end
            end else if (iss) begin
                last_rd   = int'(id_rd);
                last_we   = id_rd_we;
                last_long = id_long;
                last_prev = ready[id_rd];
                if (id_rd_we && id_rd != 5'd0) ready[id_rd] = cyc + norm_lat(int'(id_lat));
                if (id_long) mdu_ready = cyc + norm_lat(int'(id_lat));
            end
            last_vld = iss;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we,
                         int lat, bit lng, bit kill);
        id_valid    = v;
        id_rs1      = 5'(rs1);
        id_rs1_used = u1;
        id_rs2      = 5'(rs2);
        id_rs2_used = u2;
        id_rd       = 5'(rd);
        id_rd_we    = we;
        id_lat      = 4'(lat);
        id_long     = lng;
        ex_kill     = kill;
    endtask

    task automatic idle(int n);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        drive(1, 3, 1, 4, 1, 5, 1, 2, 1, 0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        vectors++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        vectors++;
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_mdu got=%b exp=0", mdu_busy); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
    endtask

    task automatic test_load_use();
        idle(10);
        drive(1, 0, 0, 0, 0, 5, 1, 2, 0, 0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_load_stall got=%b exp=0", stall); end
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b exp=1", stall); end
        vectors++;
        if (busy_mask[5] !== 1'b1) begin errors++; $display("FAIL lu_busy5_t1 got=%b exp=1", busy_mask[5]); end
        tick();
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_issue got=%b exp=0", stall); end
        vectors++;
        if (busy_mask[5] !== 1'b1) begin errors++; $display("FAIL lu_busy5_t2 got=%b exp=1", busy_mask[5]); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (busy_mask[5] !== 1'b0) begin errors++; $display("FAIL lu_busy5_t3 got=%b exp=0", busy_mask[5]); end
        vectors++;
        if (busy_mask[6] !== 1'b1) begin errors++; $display("FAIL lu_busy6_t3 got=%b exp=1", busy_mask[6]); end
        tick();
    endtask

    task automatic test_alu_chain();
        idle(10);
        drive(1, 1, 1, 2, 1, 3, 1, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_add got=%b exp=0", stall); end
        tick();
        drive(1, 3, 1, 3, 1, 3, 1, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_sub got=%b exp=0", stall); end
        tick();
        drive(1, 3, 1, 0, 0, 4, 1, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_third got=%b exp=0", stall); end
        vectors++;
        if (busy_mask !== model_busy()) begin errors++; $display("FAIL alu_busy got=%h exp=%h", busy_mask, model_busy()); end
        tick();
    endtask

    task automatic test_mdu();
        int  n = 0;
        int  busy_cycles = 0;
        bit  done = 1'b0;
        idle(10);
        drive(1, 1, 1, 2, 1, 7, 1, 4, 1, 0);
        tick();
        drive(1, 1, 1, 2, 1, 8, 1, 4, 1, 0);
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            vectors++;
            if (mdu_busy !== 1'b1) begin errors++; $display("FAIL mdu_busy_wait got=%b exp=1", mdu_busy); end
            if (stall) n++;
            else done = 1'b1;
            tick();
        end
        vectors++;
        if (!done || n != 3) begin errors++; $display("FAIL mdu_struct_stall got=%0d exp=3", n); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mdu_busy) busy_cycles++;
            tick();
        end
        vectors++;
        if (busy_cycles != 4) begin errors++; $display("FAIL mdu_busy_len got=%0d exp=4", busy_cycles); end
    endtask

    task automatic test_kill();
        idle(10);
        drive(1, 0, 0, 0, 0, 9, 1, 2, 0, 0);
        tick();
        drive(1, 9, 1, 0, 0, 11, 1, 1, 0, 1);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL kill_stall got=%b exp=0", stall); end
        tick();
        drive(1, 9, 1, 0, 0, 10, 1, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL kill_reader got=%b exp=0", stall); end
        vectors++;
        if (busy_mask[9] !== 1'b0) begin errors++; $display("FAIL kill_restore9 got=%b exp=0", busy_mask[9]); end
        vectors++;
        if (busy_mask[11] !== 1'b0) begin errors++; $display("FAIL kill_no_issue got=%b exp=0", busy_mask[11]); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (busy_mask[10] !== 1'b1) begin errors++; $display("FAIL kill_after_issue got=%b exp=1", busy_mask[10]); end
        tick();
    endtask

    task automatic test_waw();
        int n = 0;
        bit done = 1'b0;
        int exp_n;
`ifdef SB_WAW_CHECK_EN
        exp_n = 5;
`else
        exp_n = 0;
`endif
        idle(10);
        drive(1, 1, 1, 2, 1, 4, 1, 6, 1, 0);
        tick();
        drive(1, 1, 1, 2, 1, 4, 1, 1, 0, 0);
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
            tick();
        end
        vectors++;
        if (!done || n != exp_n) begin errors++; $display("FAIL waw_stalls got=%0d exp=%0d", n, exp_n); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (busy_mask[4] !== 1'b1) begin errors++; $display("FAIL waw_busy4_a got=%b exp=1", busy_mask[4]); end
        tick();
        @(negedge clk);
        vectors++;
        if (busy_mask[4] !== 1'b0) begin errors++; $display("FAIL waw_busy4_b got=%b exp=0", busy_mask[4]); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle(10);
        drive(1, 0, 0, 0, 0, 2, 1, 6, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (busy_mask[2] !== 1'b1 || mdu_busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got=%b%b exp=11", busy_mask[2], mdu_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 2, 1, 0, 0, 3, 1, 1, 1, 0);
        @(negedge clk);
        vectors++;
        if (busy_mask !== 32'h0) begin errors++; $display("FAIL rstmid_busy got=%h exp=0", busy_mask); end
        vectors++;
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL rstmid_mdu got=%b exp=0", mdu_busy); end
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
        tick();
    endtask

    task automatic test_random();
        idle(10);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 8,
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 11), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0);
            @(negedge clk);
            vectors++;
            if (busy_mask !== model_busy()) begin
                errors++; $display("FAIL rand_busy cyc=%0d got=%h exp=%h", cyc, busy_mask, model_busy());
            end
            vectors++;
            if (mdu_busy !== model_mdu_busy()) begin
                errors++; $display("FAIL rand_mdu cyc=%0d got=%b exp=%b", cyc, mdu_busy, model_mdu_busy());
            end
            if (!reset) begin
                vectors++;
                if (stall !== model_stall()) begin
                    errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, stall, model_stall());
                end
            end
            tick();
        end
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int r = 0; r < 32; r++) ready[r] = -1000;
        mdu_ready = -1000;
        last_vld  = 1'b0;
        last_rd   = 0;
        last_we   = 1'b0;
        last_long = 1'b0;
        last_prev = -1000;
        test_reset();
        test_load_use();
        test_alu_chain();
        test_mdu();
        test_kill();
        test_waw();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

- Parametrised, counter-based scoreboard and hazard unit for the 5-stage RV32 pipeline. Sits at the ID/EX boundary and generates the ID stall.
- Generalises the single load-use interlock to per-register result latencies (loads, multi-cycle ALU ops) and one shared non-pipelined iterative unit (MDU).
- Supports cancellation of the youngest issued instruction on an EX-stage branch flush.

## Interface
- NUM_REGS, 32: architectural registers tracked; x0 is never tracked.
- REG_AW, 5: register address width, equal to $clog2(NUM_REGS).
- MAX_LAT, 8: maximum result latency in cycles.
- LAT_W, $clog2(MAX_LAT+1): latency/counter width.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  REG_AW  destination register.
- id_rd_we  in  1  instruction writes rd.
- id_lat  in  LAT_W  cycles until rd is forwardable to an EX consumer; 1 = ALU, 2 = load.
- id_long  in  1  instruction uses the iterative unit.
- ex_kill  in  1  EX-stage flush (branch taken).
- stall  out  1  hold PC and IF/ID, bubble ID/EX; combinational.
- busy_mask  out  NUM_REGS  bit r = cnt[r] != 0; registered.
- mdu_busy  out  1  iterative unit occupied; registered.

## Operation
State:
- cnt[r]: LAT_W bits per register r ≥ 1. cnt[0] is constant 0.
- mdu_cnt: LAT_W bits.
- Last-issue record: last_vld, last_rd, last_we, last_long, last_prev_cnt.

Latency normalisation:
- id_lat = 0 is treated as 1.
- id_lat > MAX_LAT saturates to MAX_LAT.

Stall conditions (OR of):
- RAW: id_valid & id_rsN_used & rsN != 0 & cnt[rsN] > 1.
- Structural: id_valid & id_long & mdu_cnt > 1.
- WAW: only with the macro (see Configuration).
- ex_kill forces stall = 0; ID is being flushed, so issue is suppressed.

Issue and counters:
- issue = id_valid & ~stall & ~ex_kill.
- Every edge, each nonzero cnt[r] and mdu_cnt decrements by 1, saturating at 0.
- On issue with id_rd_we & id_rd != 0: cnt[id_rd] <= id_lat. This load overrides that register's decrement.
- On issue with id_long: mdu_cnt <= id_lat.
- Last-issue record: last_vld <= issue every cycle. When issue = 1, capture rd, we, long, and the pre-issue cnt[rd] in last_prev_cnt.

Kill:
- ex_kill with last_vld = 1 cancels the instruction now in EX:
  - If last_we & last_rd != 0: cnt[last_rd] <= sat0(last_prev_cnt − 2), i.e. the old writer's count as if never overwritten.
  - If last_long: mdu_cnt <= 0.
- ex_kill with last_vld = 0 only blocks issue.
- Kill and decrement are the only updates in a kill cycle.

Other:
- busy_mask and mdu_busy reflect post-edge state.
- Reset clears all counters, last_vld, busy_mask and mdu_busy. stall is 0 after reset until an instruction presents a hazard.
- Reset mid-operation discards all pending entries immediately.

## Timing
- stall is combinational from registered state plus ID inputs, in the same cycle; zero-cycle latency.
- A producer issued in cycle t with latency L stalls a dependent consumer in cycles t+1 .. t+L−1. The consumer issues in cycle t+L.
  - L = 1: no stall.
  - L = 2: 1 bubble (load-use).
- Back-to-back long ops: the second issues L cycles after the first.
- A stalled instruction re-evaluates every cycle; no state changes while id_valid is held with stall = 1.
- Simultaneous issue to rd and decrement of cnt[rd]: issue value wins.
- Writes to x0 never set a counter; reads of x0 never stall.

## Configuration
- SB_WAW_CHECK_EN defined: additionally stall when id_valid & id_rd_we & id_rd != 0 & cnt[id_rd] > id_lat. This prevents an older, longer op from completing after a younger write to the same rd.
- Not defined: no WAW stall; a younger issue simply overwrites cnt[rd] with its own latency.

## Test plan
- Load-use: issue load x5 (lat 2), then add x6 = x5 + x1 → stall = 1 for exactly 1 cycle; add issues in cycle t+2; busy_mask[5] clears after 2 edges.
- ALU chain: add x3 (lat 1) then sub using x3 → stall never asserts.
- MDU: mul x7 (lat 4, long) then div x8 (long, independent) → div stalls 3 cycles; mdu_busy = 1 for 4 cycles.
- Kill: load x9 issued (cnt[9] = 2); next cycle ex_kill = 1 with an instruction in ID → stall = 0, no issue, cnt[9] restored to 0; a following reader of x9 issues with no stall.
- WAW with SB_WAW_CHECK_EN: mul x4 (lat 6), then add x4 (lat 1) → add stalls until cnt[4] ≤ 1. Without the macro: add issues immediately and cnt[4] = 1.
- Reset mid-operation: assert reset while cnt[2] = 5 and mdu_cnt = 3 → next cycle busy_mask = 0, mdu_busy = 0, and a reader of x2 does not stall.
